// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller.
//   opcode_t   : MIPS-style primary opcodes seen in the pipeline registers
//   hu_state_t : hazard controller state
//   is_load()  : true for opcodes whose result is only available after MEM
package hazard_unit_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2b,
        LL    = 6'h30,
        SC    = 6'h38,
        HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [1:0] {
        HU_RUN,
        HU_DRAIN,
        HU_HALTED
    } hu_state_t;

    function automatic logic is_load(opcode_t op);
        return (op == LW) || (op == LL);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the datapath and the hazard controller.
//   hu : hazard controller side (pipeline status in, enables/flushes/counters out)
//   tb : datapath or testbench side (mirror image of hu)
interface hazard_unit_if
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             dREN_EX_MEM;
    logic             dWEN_EX_MEM;
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             rt_used_ID;
    opcode_t          opcode_ID_EX;
    logic [4:0]       reg_wr_ID_EX;
    logic             WEN_ID_EX;
    logic             branch_taken_EX;
    logic             jump_ID;
    logic             halt_MEM;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mw_cnt;
    logic [CNT_W-1:0] fl_cnt;

    modport hu (
        input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, rs_ID, rt_ID, rt_used_ID,
               opcode_ID_EX, reg_wr_ID_EX, WEN_ID_EX, branch_taken_EX, jump_ID, halt_MEM,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, lu_cnt, mw_cnt, fl_cnt
    );

    modport tb (
        output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, rs_ID, rt_ID, rt_used_ID,
               opcode_ID_EX, reg_wr_ID_EX, WEN_ID_EX, branch_taken_EX, jump_ID, halt_MEM,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, lu_cnt, mw_cnt, fl_cnt
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low clear
//   inc_i : count this cycle
//   cnt_o : current count; holds at all ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage datapath: load-use bubbles,
// data-memory wait stalls, branch/jump flushes and the halt drain.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   hif  : hazard_unit_if.hu bundle (pipeline status in, enables/flushes,
//          halted flag and lu/mw/fl performance counters out)
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   HU_RUN    | normal operation, priority: stall > branch > load-use > jump
//   HU_DRAIN  | HALT in MEM: front end frozen, EX/MEM and MEM/WB still drain
//   HU_HALTED | all enables off until reset
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic   CLK,
    input  logic   nRST,
    hazard_unit_if.hu hif
);

    hu_state_t  state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic       halted_q;

    logic mem_wait, adv, lu;
    logic lu_inc, mw_inc, fl_inc;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

    assign mem_wait = (hif.dREN_EX_MEM | hif.dWEN_EX_MEM) & ~hif.dhit;
    assign adv      = hif.ihit & ~mem_wait;
    assign lu       = is_load(hif.opcode_ID_EX) & hif.WEN_ID_EX
                    & (hif.reg_wr_ID_EX != 5'd0)
                    & ((hif.reg_wr_ID_EX == hif.rs_ID)
                       | (hif.rt_used_ID & (hif.reg_wr_ID_EX == hif.rt_ID)));

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        lu_inc     = 1'b0;
        fl_inc     = 1'b0;
        case (state_q)
            HU_RUN: begin
                if (adv) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    // A taken branch flushes the dependent instruction anyway,
                    // so it outranks the load-use bubble.
                    if (hif.branch_taken_EX) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        fl_inc     = 1'b1;
                    end else if (lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        lu_inc     = 1'b1;
                    end else if (hif.jump_ID) begin
                        ifid_flush = 1'b1;
                        fl_inc     = 1'b1;
                    end
                    if (hif.halt_MEM) begin
                        state_d = HU_DRAIN;
                        drain_d = 2'd0;
                    end
                end
            end
            HU_DRAIN: begin
                exmem_en   = adv;
                memwb_en   = adv;
                idex_flush = adv;
                if (adv) begin
                    drain_d = drain_q + 2'd1;
                    // One more advance retires HALT through MEM/WB.
                    if (drain_q + 2'd1 == 2'd1) begin
                        state_d = HU_HALTED;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign mw_inc = (state_q != HU_HALTED) & mem_wait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= HU_RUN;
            drain_q  <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == HU_HALTED);
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (.CLK(CLK), .nRST(nRST), .inc_i(lu_inc), .cnt_o(hif.lu_cnt));
    sat_counter #(.W(CNT_W)) u_mw_cnt (.CLK(CLK), .nRST(nRST), .inc_i(mw_inc), .cnt_o(hif.mw_cnt));
    sat_counter #(.W(CNT_W)) u_fl_cnt (.CLK(CLK), .nRST(nRST), .inc_i(fl_inc), .cnt_o(hif.fl_cnt));

    assign hif.pc_en      = pc_en;
    assign hif.ifid_en    = ifid_en;
    assign hif.idex_en    = idex_en;
    assign hif.exmem_en   = exmem_en;
    assign hif.memwb_en   = memwb_en;
    assign hif.ifid_flush = ifid_flush;
    assign hif.idex_flush = idex_flush;
    assign hif.halted     = halted_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit. ctl packs the controls as
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;

    hazard_unit_if #(.CNT_W(16)) hif ();
    hazard_unit_if #(.CNT_W(2))  hif2 ();

    hazard_unit #(.CNT_W(16)) dut  (.CLK(CLK), .nRST(nRST), .hif(hif.hu));
    hazard_unit #(.CNT_W(2))  dut2 (.CLK(CLK), .nRST(nRST), .hif(hif2.hu));

    logic [6:0] ctl;
    assign ctl = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                  hif.ifid_flush, hif.idex_flush};

    localparam logic [6:0] C_RUN   = 7'b1111100;
    localparam logic [6:0] C_LU    = 7'b0011101;
    localparam logic [6:0] C_STALL = 7'b0000000;
    localparam logic [6:0] C_BR    = 7'b1111111;
    localparam logic [6:0] C_JMP   = 7'b1111110;
    localparam logic [6:0] C_DRAIN = 7'b0001101;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        hif.ihit = 1'b1; hif.dhit = 1'b0; hif.dREN_EX_MEM = 1'b0; hif.dWEN_EX_MEM = 1'b0;
        hif.rs_ID = 5'd0; hif.rt_ID = 5'd0; hif.rt_used_ID = 1'b0; hif.opcode_ID_EX = RTYPE;
        hif.reg_wr_ID_EX = 5'd0; hif.WEN_ID_EX = 1'b0; hif.branch_taken_EX = 1'b0;
        hif.jump_ID = 1'b0; hif.halt_MEM = 1'b0;
    endtask

    task automatic set_idle2();
        hif2.ihit = 1'b1; hif2.dhit = 1'b0; hif2.dREN_EX_MEM = 1'b0; hif2.dWEN_EX_MEM = 1'b0;
        hif2.rs_ID = 5'd0; hif2.rt_ID = 5'd0; hif2.rt_used_ID = 1'b0; hif2.opcode_ID_EX = RTYPE;
        hif2.reg_wr_ID_EX = 5'd0; hif2.WEN_ID_EX = 1'b0; hif2.branch_taken_EX = 1'b0;
        hif2.jump_ID = 1'b0; hif2.halt_MEM = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        set_idle2();
        #2;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RUN); end
        total++; if (hif.halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", hif.halted); end
        total++; if ({hif.lu_cnt, hif.mw_cnt, hif.fl_cnt} !== 48'd0) begin bad++;
            $display("FAIL reset_cnts: got lu=%0d mw=%0d fl=%0d want 0", hif.lu_cnt, hif.mw_cnt, hif.fl_cnt); end
        @(negedge CLK);
        nRST = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        // LW r5 in EX, rs = r5 in ID
        hif.opcode_ID_EX = LW; hif.WEN_ID_EX = 1'b1; hif.reg_wr_ID_EX = 5'd5; hif.rs_ID = 5'd5;
        #1;
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs_ctl: got %b want %b", ctl, C_LU); end
        step();
        hif.opcode_ID_EX = RTYPE; hif.WEN_ID_EX = 1'b0;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_bubble_ctl: got %b want %b", ctl, C_RUN); end
        total++; if (hif.lu_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt1: got %0d want 1", hif.lu_cnt); end
        // LL r7 in EX, rt = r7 used in ID
        set_idle();
        hif.opcode_ID_EX = LL; hif.WEN_ID_EX = 1'b1; hif.reg_wr_ID_EX = 5'd7;
        hif.rs_ID = 5'd3; hif.rt_ID = 5'd7; hif.rt_used_ID = 1'b1;
        #1;
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, C_LU); end
        step();
        set_idle();
        #1;
        total++; if (hif.lu_cnt !== 16'd2) begin bad++; $display("FAIL lu_cnt2: got %0d want 2", hif.lu_cnt); end
    endtask

    task automatic test_mem_wait();
        set_idle();
        hif.dREN_EX_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctl !== C_STALL) begin bad++; $display("FAIL mw_stall%0d: got %b want %b", i, ctl, C_STALL); end
            step();
        end
        hif.dhit = 1'b1;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL mw_release: got %b want %b", ctl, C_RUN); end
        total++; if (hif.mw_cnt !== 16'd3) begin bad++; $display("FAIL mw_cnt3: got %0d want 3", hif.mw_cnt); end
        step();
        // fetch miss alone stalls but is not a memory wait
        set_idle();
        hif.ihit = 1'b0;
        #1;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL ihit_stall: got %b want %b", ctl, C_STALL); end
        step();
        set_idle();
        #1;
        total++; if (hif.mw_cnt !== 16'd3) begin bad++; $display("FAIL mw_ihit: got %0d want 3", hif.mw_cnt); end
    endtask

    task automatic test_flush();
        // branch together with load-use: branch wins
        set_idle();
        hif.opcode_ID_EX = LW; hif.WEN_ID_EX = 1'b1; hif.reg_wr_ID_EX = 5'd5; hif.rs_ID = 5'd5;
        hif.branch_taken_EX = 1'b1;
        #1;
        total++; if (ctl !== C_BR) begin bad++; $display("FAIL br_lu_ctl: got %b want %b", ctl, C_BR); end
        step();
        set_idle();
        #1;
        total++; if (hif.fl_cnt !== 16'd1) begin bad++; $display("FAIL br_fl_cnt: got %0d want 1", hif.fl_cnt); end
        total++; if (hif.lu_cnt !== 16'd2) begin bad++; $display("FAIL br_lu_cnt: got %0d want 2", hif.lu_cnt); end
        // memory stall together with branch: stall first, flush on advance
        hif.dWEN_EX_MEM = 1'b1; hif.branch_taken_EX = 1'b1;
        #1;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL br_mw_stall: got %b want %b", ctl, C_STALL); end
        step();
        hif.dhit = 1'b1;
        #1;
        total++; if (ctl !== C_BR) begin bad++; $display("FAIL br_mw_adv: got %b want %b", ctl, C_BR); end
        step();
        set_idle();
        #1;
        total++; if (hif.fl_cnt !== 16'd2) begin bad++; $display("FAIL br_mw_fl: got %0d want 2", hif.fl_cnt); end
        total++; if (hif.mw_cnt !== 16'd4) begin bad++; $display("FAIL br_mw_mw: got %0d want 4", hif.mw_cnt); end
        // jump alone
        hif.jump_ID = 1'b1;
        #1;
        total++; if (ctl !== C_JMP) begin bad++; $display("FAIL jmp_ctl: got %b want %b", ctl, C_JMP); end
        step();
        // jump with load-use: load-use wins
        hif.opcode_ID_EX = LW; hif.WEN_ID_EX = 1'b1; hif.reg_wr_ID_EX = 5'd9; hif.rs_ID = 5'd9;
        #1;
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL jmp_lu_ctl: got %b want %b", ctl, C_LU); end
        step();
        set_idle();
        #1;
        total++; if (hif.fl_cnt !== 16'd3) begin bad++; $display("FAIL jmp_fl: got %0d want 3", hif.fl_cnt); end
        total++; if (hif.lu_cnt !== 16'd3) begin bad++; $display("FAIL jmp_lu: got %0d want 3", hif.lu_cnt); end
    endtask

    task automatic test_no_stall();
        set_idle();
        hif.opcode_ID_EX = LW; hif.WEN_ID_EX = 1'b1; hif.reg_wr_ID_EX = 5'd0; hif.rs_ID = 5'd0;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL ns_r0: got %b want %b", ctl, C_RUN); end
        hif.reg_wr_ID_EX = 5'd9; hif.rs_ID = 5'd1; hif.rt_ID = 5'd9; hif.rt_used_ID = 1'b0;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL ns_rt_unused: got %b want %b", ctl, C_RUN); end
        hif.rs_ID = 5'd9; hif.WEN_ID_EX = 1'b0;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL ns_wen0: got %b want %b", ctl, C_RUN); end
        hif.WEN_ID_EX = 1'b1; hif.opcode_ID_EX = ADDI;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL ns_addi: got %b want %b", ctl, C_RUN); end
        step();
        set_idle();
        #1;
        total++; if (hif.lu_cnt !== 16'd3) begin bad++; $display("FAIL ns_lu_cnt: got %0d want 3", hif.lu_cnt); end
    endtask

    task automatic test_halt();
        set_idle();
        hif.halt_MEM = 1'b1;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL halt_run: got %b want %b", ctl, C_RUN); end
        step();
        hif.halt_MEM = 1'b0;
        #1;
        total++; if (ctl !== C_DRAIN) begin bad++; $display("FAIL drain_ctl: got %b want %b", ctl, C_DRAIN); end
        total++; if (hif.halted !== 1'b0) begin bad++; $display("FAIL drain_halted: got %b want 0", hif.halted); end
        hif.ihit = 1'b0;
        #1;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL drain_noadv: got %b want %b", ctl, C_STALL); end
        step();
        total++; if (hif.halted !== 1'b0) begin bad++; $display("FAIL drain_hold: got %b want 0", hif.halted); end
        hif.ihit = 1'b1;
        #1;
        total++; if (ctl !== C_DRAIN) begin bad++; $display("FAIL drain_adv: got %b want %b", ctl, C_DRAIN); end
        step();
        total++; if (hif.halted !== 1'b1) begin bad++; $display("FAIL halted: got %b want 1", hif.halted); end
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL halted_ctl: got %b want %b", ctl, C_STALL); end
        hif.dREN_EX_MEM = 1'b1;
        step();
        total++; if (hif.mw_cnt !== 16'd4) begin bad++; $display("FAIL halted_mw: got %0d want 4", hif.mw_cnt); end
        total++; if (hif.halted !== 1'b1) begin bad++; $display("FAIL halted_stay: got %b want 1", hif.halted); end
        // reset mid-DRAIN
        set_idle();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        step();
        hif.halt_MEM = 1'b1;
        step();
        hif.halt_MEM = 1'b0;
        #1;
        total++; if (ctl !== C_DRAIN) begin bad++; $display("FAIL redrain_ctl: got %b want %b", ctl, C_DRAIN); end
        nRST = 1'b0;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL rst_drain_ctl: got %b want %b", ctl, C_RUN); end
        total++; if ({hif.lu_cnt, hif.mw_cnt, hif.fl_cnt} !== 48'd0) begin bad++;
            $display("FAIL rst_drain_cnts: got lu=%0d mw=%0d fl=%0d want 0", hif.lu_cnt, hif.mw_cnt, hif.fl_cnt); end
        #1;
        nRST = 1'b1;
        step();
        total++; if (hif.halted !== 1'b0 || ctl !== C_RUN) begin bad++;
            $display("FAIL post_rst: got halted=%b ctl=%b want 0 %b", hif.halted, ctl, C_RUN); end
    endtask

    task automatic test_saturate();
        int exp;
        set_idle2();
        for (int i = 1; i <= 5; i++) begin
            hif2.opcode_ID_EX = LW; hif2.WEN_ID_EX = 1'b1; hif2.reg_wr_ID_EX = 5'd4; hif2.rs_ID = 5'd4;
            step();
            hif2.opcode_ID_EX = RTYPE; hif2.WEN_ID_EX = 1'b0;
            #1;
            exp = (i > 3) ? 3 : i;
            total++; if (hif2.lu_cnt !== 2'(exp)) begin bad++;
                $display("FAIL sat_lu%0d: got %0d want %0d", i, hif2.lu_cnt, exp); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_flush();
        test_no_stall();
        test_halt();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
